p2s_feeder: RTL and testbench



---
 rtl/p2s_feeder_if.sv | 28 ++
 rtl/p2s_feeder.sv | 143 ++++++++++++++
 tb/tb_p2s_feeder.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/p2s_feeder_if.sv
// Byte handshake in, load strobe/byte out for the p2s_feeder block.
// master: upstream producer / shifter side; slave: the feeder itself.
interface p2s_feeder_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       sof_out;
    logic [7:0] dout;
    logic       busy;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  sof_out,
        input  dout,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output sof_out,
        output dout,
        output busy
    );
endinterface

// File: rtl/p2s_feeder.sv
// p2s_feeder: buffers bytes in a small FIFO and issues one byte per
// 8+GAP cycle frame to a parallel-to-serial shifter with a SOF strobe.
// Optional feature macro FIFO_LVL_EN adds level_o and ovf_sticky_o.
// in_ready is combinational from the registered FIFO count.
module p2s_feeder #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned GAP    = 0
) (
    input  logic          clk,
    input  logic          rst,
    p2s_feeder_if.slave   bus
`ifdef FIFO_LVL_EN
    ,
    output logic [ADDR_W:0] level_o,
    output logic            ovf_sticky_o
`endif
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [3:0]       SLOT_LAST = 4'(7 + GAP);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

    typedef enum logic {IDLE, SEND} state_e;

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    state_e            state_q, state_d;
    logic [3:0]        slot_q, slot_d;
    logic              sof_q, sof_d;
    logic [7:0]        dout_q, dout_d;
    logic              busy_q, busy_d;
    logic              push, pop;

    assign bus.in_ready = (count_q != FULL_CNT);
    assign bus.sof_out  = sof_q;
    assign bus.dout     = dout_q;
    assign bus.busy     = busy_q;

    assign push = bus.in_valid & bus.in_ready;

    // FIFO storage write port; contents need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    // Frame sequencing, pops and pointer/count next-state
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        sof_d    = 1'b0;
        dout_d   = dout_q;
        pop      = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    dout_d  = mem_q[rd_ptr_q];
                    sof_d   = 1'b1;
                    slot_d  = 4'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (slot_q == SLOT_LAST) begin
                    slot_d = 4'd0;
                    if (count_q != '0) begin
                        pop    = 1'b1;
                        dout_d = mem_q[rd_ptr_q];
                        sof_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    slot_d = slot_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        busy_d = (state_d == SEND);
    end

    // State, pointers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            slot_q   <= 4'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sof_q    <= 1'b0;
            dout_q   <= 8'h00;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            sof_q    <= sof_d;
            dout_q   <= dout_d;
            busy_q   <= busy_d;
        end
    end

`ifdef FIFO_LVL_EN
    logic ovf_q;

    assign level_o      = count_q;
    assign ovf_sticky_o = ovf_q;

    // Sticky flag for a valid byte offered while the FIFO is full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (bus.in_valid && !bus.in_ready) begin
            ovf_q <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_p2s_feeder.sv
// Bench for p2s_feeder: two instances (GAP=0 and GAP=3) share stimulus and
// are compared every cycle against a frame-countdown model of the feeder.
module tb_p2s_feeder;

    localparam int unsigned DEPTH = 4;
    localparam int GAPS [2] = '{0, 3};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tb_valid = 1'b0;
    logic [7:0] tb_data = 8'h00;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    p2s_feeder_if bus0 ();
    p2s_feeder_if bus1 ();

    assign bus0.in_valid = tb_valid;
    assign bus0.in_data  = tb_data;
    assign bus1.in_valid = tb_valid;
    assign bus1.in_data  = tb_data;

`ifdef FIFO_LVL_EN
    logic [2:0] lvl0, lvl1;
    logic       ovf0, ovf1;
`endif

    p2s_feeder #(.DEPTH(4), .ADDR_W(2), .GAP(0)) dut0 (
        .clk(clk),
        .rst(rst),
        .bus(bus0.slave)
`ifdef FIFO_LVL_EN
        ,
        .level_o(lvl0),
        .ovf_sticky_o(ovf0)
`endif
    );

    p2s_feeder #(.DEPTH(4), .ADDR_W(2), .GAP(3)) dut1 (
        .clk(clk),
        .rst(rst),
        .bus(bus1.slave)
`ifdef FIFO_LVL_EN
        ,
        .level_o(lvl1),
        .ovf_sticky_o(ovf1)
`endif
    );

    logic [1:0] d_sof, d_busy, d_rdy;
    logic [7:0] d_dout [2];
    assign d_sof     = {bus1.sof_out, bus0.sof_out};
    assign d_busy    = {bus1.busy, bus0.busy};
    assign d_rdy     = {bus1.in_ready, bus0.in_ready};
    assign d_dout[0] = bus0.dout;
    assign d_dout[1] = bus1.dout;

    always #5 clk = ~clk;

    // Model: every accepted byte is logged in order; the FIFO is the slice
    // between the pop and push counts. fl counts cycles left in the frame.
    logic [7:0] pushed [2][4096];
    int np [2]    = '{0, 0};
    int npop [2]  = '{0, 0};
    int fl [2]    = '{0, 0};
    logic m_sof [2]  = '{1'b0, 1'b0};
    logic [7:0] m_dout [2] = '{8'h00, 8'h00};
    logic m_busy [2] = '{1'b0, 1'b0};
    logic m_ovf [2]  = '{1'b0, 1'b0};

    // Strobe log: cycle and byte of every SOF seen on each instance
    int s_cyc [2][256];
    logic [7:0] s_dat [2][256];
    int ns [2] = '{0, 0};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            np[k] = 0; npop[k] = 0; fl[k] = 0;
            m_sof[k] = 1'b0; m_dout[k] = 8'h00; m_busy[k] = 1'b0; m_ovf[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        int sz;
        bit acc;
        for (int k = 0; k < 2; k++) begin
            sz  = np[k] - npop[k];
            acc = tb_valid && (sz < int'(DEPTH));
            if (tb_valid && sz == int'(DEPTH)) m_ovf[k] = 1'b1;
            m_sof[k] = 1'b0;
            if (fl[k] <= 1) begin
                if (sz > 0) begin
                    m_dout[k] = pushed[k][npop[k]];
                    npop[k]++;
                    m_sof[k] = 1'b1;
                    fl[k] = 8 + GAPS[k];
                end else begin
                    fl[k] = 0;
                end
            end else begin
                fl[k]--;
            end
            if (acc && np[k] < 4096) begin
                pushed[k][np[k]] = tb_data;
                np[k]++;
            end
            m_busy[k] = (fl[k] != 0);
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) model_reset();
        else     model_step();
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Per-cycle compare of both instances against the model
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (d_sof[k] && ns[k] < 256) begin
                s_cyc[k][ns[k]] = cyc;
                s_dat[k][ns[k]] = d_dout[k];
                ns[k]++;
            end
            chk($sformatf("sof%0d", k), 32'(d_sof[k]), 32'(m_sof[k]));
            chk($sformatf("dout%0d", k), 32'(d_dout[k]), 32'(m_dout[k]));
            chk($sformatf("busy%0d", k), 32'(d_busy[k]), 32'(m_busy[k]));
            chk($sformatf("ready%0d", k), 32'(d_rdy[k]), 32'((np[k] - npop[k]) < int'(DEPTH)));
        end
`ifdef FIFO_LVL_EN
        chk("level0", 32'(lvl0), 32'(np[0] - npop[0]));
        chk("level1", 32'(lvl1), 32'(np[1] - npop[1]));
        chk("ovf0", 32'(ovf0), 32'(m_ovf[0]));
        chk("ovf1", 32'(ovf1), 32'(m_ovf[1]));
`endif
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b0, b1, acc, nb;
        bit will;

        // Reset then idle
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_sof", 32'(bus0.sof_out), 32'd0);
        chk("idle_dout", 32'(bus0.dout), 32'h00);
        chk("idle_busy", 32'(bus0.busy), 32'd0);
        chk("idle_ready", 32'(bus0.in_ready), 32'd1);

        // Single byte latency and frame length
        tb_valid = 1'b1; tb_data = 8'hA5;
        @(negedge clk);
        tb_valid = 1'b0;
        chk("a5_no_sof_yet", 32'(bus0.sof_out), 32'd0);
        @(negedge clk);
        chk("a5_sof0", 32'(bus0.sof_out), 32'd1);
        chk("a5_dout0", 32'(bus0.dout), 32'hA5);
        chk("a5_sof1", 32'(bus1.sof_out), 32'd1);
        b0 = int'(bus0.busy); b1 = int'(bus1.busy);
        repeat (15) begin
            @(negedge clk);
            b0 += int'(bus0.busy); b1 += int'(bus1.busy);
        end
        chk("a5_busy_len_gap0", 32'(b0), 32'd8);
        chk("a5_busy_len_gap3", 32'(b1), 32'd11);

        // Back-to-back frames
        b0 = ns[0]; b1 = ns[1];
        tb_valid = 1'b1; tb_data = 8'h11;
        @(negedge clk); tb_data = 8'h22;
        @(negedge clk); tb_data = 8'h33;
        @(negedge clk); tb_valid = 1'b0;
        repeat (50) @(negedge clk);
        chk("b2b_count0", 32'(ns[0] - b0), 32'd3);
        chk("b2b_count1", 32'(ns[1] - b1), 32'd3);
        if (ns[0] - b0 == 3 && ns[1] - b1 == 3) begin
            chk("b2b_d0", 32'(s_dat[0][b0]), 32'h11);
            chk("b2b_d1", 32'(s_dat[0][b0+1]), 32'h22);
            chk("b2b_d2", 32'(s_dat[0][b0+2]), 32'h33);
            chk("b2b_sp0a", 32'(s_cyc[0][b0+1] - s_cyc[0][b0]), 32'd8);
            chk("b2b_sp0b", 32'(s_cyc[0][b0+2] - s_cyc[0][b0+1]), 32'd8);
            chk("b2b_sp1a", 32'(s_cyc[1][b1+1] - s_cyc[1][b1]), 32'd11);
            chk("b2b_sp1b", 32'(s_cyc[1][b1+2] - s_cyc[1][b1+1]), 32'd11);
        end

        // Hold valid: fill to full, then ten bytes across pointer wrap
        acc = 0;
        tb_valid = 1'b1; tb_data = 8'h40;
        for (int i = 0; i < 200 && acc < 10; i++) begin
            will = bus0.in_ready;
            @(negedge clk);
            if (will) begin
                acc++;
                tb_data = 8'(8'h40 + acc);
            end
            if (i == 5) begin
                chk("fill_accepted5", 32'(acc), 32'd5);
                chk("fill_ready_low", 32'(bus0.in_ready), 32'd0);
`ifdef FIFO_LVL_EN
                chk("fill_level4", 32'(lvl0), 32'd4);
`endif
            end
        end
        tb_valid = 1'b0;
        chk("fill_acc10", 32'(acc), 32'd10);
        repeat (150) @(negedge clk);
        nb = ns[0] - 10;
        if (nb >= 0) begin
            for (int i = 0; i < 10; i++) begin
                chk($sformatf("wrap_order%0d", i), 32'(s_dat[0][nb+i]), 32'(8'h40 + i));
            end
        end
`ifdef FIFO_LVL_EN
        chk("ovf_stays_set", 32'(ovf0), 32'd1);
`endif

        // Reset at slot 3 with two bytes queued
        tb_valid = 1'b1; tb_data = 8'h71;
        @(negedge clk); tb_data = 8'h72;
        @(negedge clk); tb_data = 8'h73;
        @(negedge clk); tb_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_sof", 32'(bus0.sof_out), 32'd0);
        chk("rst_dout", 32'(bus0.dout), 32'h00);
        chk("rst_busy", 32'(bus0.busy), 32'd0);
        chk("rst_ready", 32'(bus0.in_ready), 32'd1);
`ifdef FIFO_LVL_EN
        chk("rst_ovf_clear", 32'(ovf0), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        b0 = ns[0]; b1 = ns[1];
        repeat (20) @(negedge clk);
        chk("post_rst_quiet0", 32'(ns[0] - b0), 32'd0);
        chk("post_rst_quiet1", 32'(ns[1] - b1), 32'd0);
        tb_valid = 1'b1; tb_data = 8'hC3;
        @(negedge clk); tb_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_sof", 32'(bus0.sof_out), 32'd1);
        chk("post_rst_dout", 32'(bus0.dout), 32'hC3);
        repeat (15) @(negedge clk);

        // Randomized traffic, checked by the per-cycle compare
        repeat (600) begin
            tb_valid = ($urandom_range(0, 3) != 0);
            tb_data  = 8'($urandom);
            @(negedge clk);
        end
        tb_valid = 1'b0;
        repeat (120) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
